rs_alu_ent_buf: RTL and testbench

- Reservation-station buffer for the ALU pipe; the consumer side of dispatch source-operand selection.
- Each source operand arrives either as a valid value, or, when not valid, as a zero-extended RRF tag in the low RRF_ENT_SEL bits.
- The buffer holds entries, captures writeback broadcasts whose tag matches a pending operand, and issues one fully ready entry per cycle to the ALU.

---
 rtl/rs_alu_ent_buf.sv | 224 ++++++++++++++++++++++
 tb/tb_rs_alu_ent_buf.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu_ent_buf.sv
// Reservation-station buffer for the ALU pipe.
// Dispatch writes the lowest free entry. Each source operand is held either
// as a value or, while pending, as a zero-extended RRF tag. Writeback
// broadcasts wake pending operands. One fully ready entry issues per cycle,
// chosen by lowest index.
//
// Handshakes (strict valid/ready on both sides):
//   dispatch: a transfer happens on a rising edge when i_dp_vld && o_dp_rdy.
//             o_dp_rdy depends only on registered state, and i_dp_vld with
//             o_dp_rdy=0 is dropped.
//   issue:    a transfer happens on a rising edge when o_iss_vld && i_iss_rdy.
//             o_iss_* depend only on registered state, and they hold while
//             stalled unless a lower-index entry becomes ready.
module rs_alu_ent_buf #(
  parameter int RS_ENT_NUM   = 4,
  parameter int RS_ENT_SEL   = 2,
  parameter int RRF_ENT_SEL  = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic                    i_dp_vld,
  output logic                    o_dp_rdy,
  input  logic                    i_dp_srcopr1_vld,
  input  logic [DATA_WIDTH-1:0]   i_dp_srcopr1,
  input  logic                    i_dp_srcopr2_vld,
  input  logic [DATA_WIDTH-1:0]   i_dp_srcopr2,
  input  logic [RRF_ENT_SEL-1:0]  i_dp_rrftag,
  input  logic [ALU_OP_WIDTH-1:0] i_dp_alu_op,
  input  logic                    i_wb0_vld,
  input  logic [RRF_ENT_SEL-1:0]  i_wb0_rrftag,
  input  logic [DATA_WIDTH-1:0]   i_wb0_data,
  input  logic                    i_wb1_vld,
  input  logic [RRF_ENT_SEL-1:0]  i_wb1_rrftag,
  input  logic [DATA_WIDTH-1:0]   i_wb1_data,
  output logic                    o_iss_vld,
  input  logic                    i_iss_rdy,
  output logic [DATA_WIDTH-1:0]   o_iss_srcopr1,
  output logic [DATA_WIDTH-1:0]   o_iss_srcopr2,
  output logic [RRF_ENT_SEL-1:0]  o_iss_rrftag,
  output logic [ALU_OP_WIDTH-1:0] o_iss_alu_op,
  output logic [RS_ENT_SEL:0]     o_ent_cnt
);

  // Entry state
  logic [RS_ENT_NUM-1:0]   busy;
  logic [RS_ENT_NUM-1:0]   opr1_vld;
  logic [RS_ENT_NUM-1:0]   opr2_vld;
  logic [DATA_WIDTH-1:0]   opr1   [RS_ENT_NUM];
  logic [DATA_WIDTH-1:0]   opr2   [RS_ENT_NUM];
  logic [RRF_ENT_SEL-1:0]  rrftag [RS_ENT_NUM];
  logic [ALU_OP_WIDTH-1:0] alu_op [RS_ENT_NUM];
  logic [RS_ENT_SEL:0]     cnt;

  // Next-state
  logic [RS_ENT_NUM-1:0]   busy_nxt;
  logic [RS_ENT_NUM-1:0]   opr1_vld_nxt;
  logic [RS_ENT_NUM-1:0]   opr2_vld_nxt;
  logic [DATA_WIDTH-1:0]   opr1_nxt   [RS_ENT_NUM];
  logic [DATA_WIDTH-1:0]   opr2_nxt   [RS_ENT_NUM];
  logic [RRF_ENT_SEL-1:0]  rrftag_nxt [RS_ENT_NUM];
  logic [ALU_OP_WIDTH-1:0] alu_op_nxt [RS_ENT_NUM];
  logic [RS_ENT_SEL:0]     cnt_nxt;

  // Selection and handshake
  logic [RS_ENT_NUM-1:0]   ready;
  logic [RS_ENT_NUM-1:0]   free_oh;
  logic [RS_ENT_NUM-1:0]   iss_oh;
  logic [RS_ENT_SEL-1:0]   iss_idx;
  logic                    dp_rdy;
  logic                    dp_fire;
  logic                    iss_vld;
  logic                    iss_fire;

  // Dispatch operands after same-cycle writeback bypass
  logic                    dp_opr1_vld;
  logic                    dp_opr2_vld;
  logic [DATA_WIDTH-1:0]   dp_opr1;
  logic [DATA_WIDTH-1:0]   dp_opr2;

  // Readiness, lowest-index selection and the handshake fires; all of this comes from registered state
  always_comb begin
    ready    = busy & opr1_vld & opr2_vld;
    // Isolate the lowest clear bit of busy and the lowest set bit of ready
    free_oh  = ~busy & (busy + RS_ENT_NUM'(1));
    iss_oh   = ready & (~ready + RS_ENT_NUM'(1));
    dp_rdy   = ~&busy;
    iss_vld  = |ready;
    dp_fire  = i_dp_vld && dp_rdy;
    iss_fire = iss_vld && i_iss_rdy;
  end

  // Encode the issue one-hot into an index for the output mux
  always_comb begin
    iss_idx = '0;
    for (int i = 0; i < RS_ENT_NUM; i++) begin
      if (iss_oh[i]) iss_idx = RS_ENT_SEL'(i);
    end
  end

  // Dispatch bypass: a pending operand whose tag is on a writeback port this cycle enters as a value
  always_comb begin
    dp_opr1_vld = i_dp_srcopr1_vld;
    dp_opr1     = i_dp_srcopr1;
    dp_opr2_vld = i_dp_srcopr2_vld;
    dp_opr2     = i_dp_srcopr2;
    if (!i_dp_srcopr1_vld) begin
      if (i_wb0_vld && (i_dp_srcopr1[RRF_ENT_SEL-1:0] == i_wb0_rrftag)) begin
        dp_opr1_vld = 1'b1;
        dp_opr1     = i_wb0_data;
      end else if (i_wb1_vld && (i_dp_srcopr1[RRF_ENT_SEL-1:0] == i_wb1_rrftag)) begin
        dp_opr1_vld = 1'b1;
        dp_opr1     = i_wb1_data;
      end
    end
    if (!i_dp_srcopr2_vld) begin
      if (i_wb0_vld && (i_dp_srcopr2[RRF_ENT_SEL-1:0] == i_wb0_rrftag)) begin
        dp_opr2_vld = 1'b1;
        dp_opr2     = i_wb0_data;
      end else if (i_wb1_vld && (i_dp_srcopr2[RRF_ENT_SEL-1:0] == i_wb1_rrftag)) begin
        dp_opr2_vld = 1'b1;
        dp_opr2     = i_wb1_data;
      end
    end
  end

  // Per-entry next state: wakeup, issue clear, dispatch write, then flush wins over everything
  always_comb begin
    busy_nxt     = busy;
    opr1_vld_nxt = opr1_vld;
    opr2_vld_nxt = opr2_vld;
    for (int i = 0; i < RS_ENT_NUM; i++) begin
      opr1_nxt[i]   = opr1[i];
      opr2_nxt[i]   = opr2[i];
      rrftag_nxt[i] = rrftag[i];
      alu_op_nxt[i] = alu_op[i];
    end
    for (int i = 0; i < RS_ENT_NUM; i++) begin
      // Port 0 takes priority if both ports carry the same tag
      if (busy[i] && !opr1_vld[i]) begin
        if (i_wb0_vld && (opr1[i][RRF_ENT_SEL-1:0] == i_wb0_rrftag)) begin
          opr1_vld_nxt[i] = 1'b1;
          opr1_nxt[i]     = i_wb0_data;
        end else if (i_wb1_vld && (opr1[i][RRF_ENT_SEL-1:0] == i_wb1_rrftag)) begin
          opr1_vld_nxt[i] = 1'b1;
          opr1_nxt[i]     = i_wb1_data;
        end
      end
      if (busy[i] && !opr2_vld[i]) begin
        if (i_wb0_vld && (opr2[i][RRF_ENT_SEL-1:0] == i_wb0_rrftag)) begin
          opr2_vld_nxt[i] = 1'b1;
          opr2_nxt[i]     = i_wb0_data;
        end else if (i_wb1_vld && (opr2[i][RRF_ENT_SEL-1:0] == i_wb1_rrftag)) begin
          opr2_vld_nxt[i] = 1'b1;
          opr2_nxt[i]     = i_wb1_data;
        end
      end
      // The issued entry is busy and the dispatch target is free, so they never collide
      if (iss_fire && iss_oh[i]) begin
        busy_nxt[i] = 1'b0;
      end
      if (dp_fire && free_oh[i]) begin
        busy_nxt[i]     = 1'b1;
        opr1_vld_nxt[i] = dp_opr1_vld;
        opr1_nxt[i]     = dp_opr1;
        opr2_vld_nxt[i] = dp_opr2_vld;
        opr2_nxt[i]     = dp_opr2;
        rrftag_nxt[i]   = i_dp_rrftag;
        alu_op_nxt[i]   = i_dp_alu_op;
      end
    end
    if (i_flush) begin
      busy_nxt = '0;
    end
  end

  // Occupancy: simultaneous dispatch and issue leave it unchanged; flush empties it
  always_comb begin
    cnt_nxt = cnt + {{RS_ENT_SEL{1'b0}}, dp_fire} - {{RS_ENT_SEL{1'b0}}, iss_fire};
    if (i_flush) cnt_nxt = '0;
  end

  // Control state register with asynchronous clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy     <= '0;
      opr1_vld <= '0;
      opr2_vld <= '0;
      cnt      <= '0;
    end else begin
      busy     <= busy_nxt;
      opr1_vld <= opr1_vld_nxt;
      opr2_vld <= opr2_vld_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Payload registers; their contents only matter while the entry is busy
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < RS_ENT_NUM; i++) begin
      opr1[i]   <= opr1_nxt[i];
      opr2[i]   <= opr2_nxt[i];
      rrftag[i] <= rrftag_nxt[i];
      alu_op[i] <= alu_op_nxt[i];
    end
  end

  // Outputs
  assign o_dp_rdy      = dp_rdy;
  assign o_iss_vld     = iss_vld;
  assign o_iss_srcopr1 = opr1[iss_idx];
  assign o_iss_srcopr2 = opr2[iss_idx];
  assign o_iss_rrftag  = rrftag[iss_idx];
  assign o_iss_alu_op  = alu_op[iss_idx];
  assign o_ent_cnt     = cnt;

  // Two writeback ports never broadcast the same tag in one cycle
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_wb0_vld && i_wb1_vld && (i_wb0_rrftag == i_wb1_rrftag)))
    else $error("wb0 and wb1 broadcast the same rrftag");

endmodule

// File: tb/tb_rs_alu_ent_buf.sv
// Testbench for rs_alu_ent_buf. Expected issue packets are queued when their
// dispatch is driven and popped and compared when the buffer presents them.
module tb_rs_alu_ent_buf;
  localparam int DW = 32;
  localparam int TW = 6;
  localparam int OW = 4;
  localparam int PW = 2 * DW + TW + OW;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_flush;
  logic          i_dp_vld;
  logic          o_dp_rdy;
  logic          i_dp_srcopr1_vld;
  logic [DW-1:0] i_dp_srcopr1;
  logic          i_dp_srcopr2_vld;
  logic [DW-1:0] i_dp_srcopr2;
  logic [TW-1:0] i_dp_rrftag;
  logic [OW-1:0] i_dp_alu_op;
  logic          i_wb0_vld;
  logic [TW-1:0] i_wb0_rrftag;
  logic [DW-1:0] i_wb0_data;
  logic          i_wb1_vld;
  logic [TW-1:0] i_wb1_rrftag;
  logic [DW-1:0] i_wb1_data;
  logic          o_iss_vld;
  logic          i_iss_rdy;
  logic [DW-1:0] o_iss_srcopr1;
  logic [DW-1:0] o_iss_srcopr2;
  logic [TW-1:0] o_iss_rrftag;
  logic [OW-1:0] o_iss_alu_op;
  logic [2:0]    o_ent_cnt;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_pkt;
  logic [PW-1:0] exp_pkt;

  rs_alu_ent_buf dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_dp_vld(i_dp_vld), .o_dp_rdy(o_dp_rdy),
    .i_dp_srcopr1_vld(i_dp_srcopr1_vld), .i_dp_srcopr1(i_dp_srcopr1),
    .i_dp_srcopr2_vld(i_dp_srcopr2_vld), .i_dp_srcopr2(i_dp_srcopr2),
    .i_dp_rrftag(i_dp_rrftag), .i_dp_alu_op(i_dp_alu_op),
    .i_wb0_vld(i_wb0_vld), .i_wb0_rrftag(i_wb0_rrftag), .i_wb0_data(i_wb0_data),
    .i_wb1_vld(i_wb1_vld), .i_wb1_rrftag(i_wb1_rrftag), .i_wb1_data(i_wb1_data),
    .o_iss_vld(o_iss_vld), .i_iss_rdy(i_iss_rdy),
    .o_iss_srcopr1(o_iss_srcopr1), .o_iss_srcopr2(o_iss_srcopr2),
    .o_iss_rrftag(o_iss_rrftag), .o_iss_alu_op(o_iss_alu_op),
    .o_ent_cnt(o_ent_cnt)
  );

  // Clock and watchdog
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic idle_inputs();
    i_flush          = 1'b0;
    i_dp_vld         = 1'b0;
    i_dp_srcopr1_vld = 1'b0;
    i_dp_srcopr1     = '0;
    i_dp_srcopr2_vld = 1'b0;
    i_dp_srcopr2     = '0;
    i_dp_rrftag      = '0;
    i_dp_alu_op      = '0;
    i_wb0_vld        = 1'b0;
    i_wb0_rrftag     = '0;
    i_wb0_data       = '0;
    i_wb1_vld        = 1'b0;
    i_wb1_rrftag     = '0;
    i_wb1_data       = '0;
  endtask

  task automatic drive_dp(input logic v1, input logic [DW-1:0] o1,
                          input logic v2, input logic [DW-1:0] o2,
                          input logic [TW-1:0] tag, input logic [OW-1:0] op);
    i_dp_vld         = 1'b1;
    i_dp_srcopr1_vld = v1;
    i_dp_srcopr1     = o1;
    i_dp_srcopr2_vld = v2;
    i_dp_srcopr2     = o2;
    i_dp_rrftag      = tag;
    i_dp_alu_op      = op;
  endtask

  task automatic drive_wb0(input logic [TW-1:0] tag, input logic [DW-1:0] d);
    i_wb0_vld = 1'b1; i_wb0_rrftag = tag; i_wb0_data = d;
  endtask

  task automatic drive_wb1(input logic [TW-1:0] tag, input logic [DW-1:0] d);
    i_wb1_vld = 1'b1; i_wb1_rrftag = tag; i_wb1_data = d;
  endtask

  function automatic logic [PW-1:0] pack(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [TW-1:0] t, input logic [OW-1:0] op);
    return {a, b, t, op};
  endfunction

  // Scoreboard pop; an empty queue yields all-X so the following compare fails
  function automatic logic [PW-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    @(negedge i_clk);
    checks++; if (o_ent_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", o_ent_cnt); end
    checks++; if (o_iss_vld !== 1'b0) begin errors++; $display("FAIL reset_iss_vld got %b exp 0", o_iss_vld); end
    checks++; if (o_dp_rdy !== 1'b1) begin errors++; $display("FAIL reset_dp_rdy got %b exp 1", o_dp_rdy); end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++; if (o_ent_cnt !== 3'd0) begin errors++; $display("FAIL post_reset_cnt got %0d exp 0", o_ent_cnt); end
  endtask

  task automatic test_basic();
    @(negedge i_clk);
    checks++; if (o_iss_vld !== 1'b0) begin errors++; $display("FAIL basic_empty got %b exp 0", o_iss_vld); end
    drive_dp(1'b1, 32'h5, 1'b1, 32'h7, 6'd3, 4'h1);
    exp_q.push_back(pack(32'h5, 32'h7, 6'd3, 4'h1));
    @(negedge i_clk);
    idle_inputs();
    checks++; if (o_iss_vld !== 1'b1) begin errors++; $display("FAIL basic_iss_vld got %b exp 1", o_iss_vld); end
    checks++; if (o_ent_cnt !== 3'd1) begin errors++; $display("FAIL basic_cnt got %0d exp 1", o_ent_cnt); end
    got_pkt = {o_iss_srcopr1, o_iss_srcopr2, o_iss_rrftag, o_iss_alu_op};
    exp_pkt = pop_exp();
    checks++; if (got_pkt !== exp_pkt) begin errors++; $display("FAIL basic_pkt got %h exp %h", got_pkt, exp_pkt); end
    i_iss_rdy = 1'b1;
    @(negedge i_clk);
    i_iss_rdy = 1'b0;
    checks++; if (o_ent_cnt !== 3'd0) begin errors++; $display("FAIL basic_cnt_after got %0d exp 0", o_ent_cnt); end
    checks++; if (o_iss_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_after got %b exp 0", o_iss_vld); end
  endtask

  task automatic test_wakeup();
    @(negedge i_clk);
    drive_dp(1'b0, 32'd9, 1'b1, 32'h11, 6'd5, 4'h2);
    exp_q.push_back(pack(32'hDEAD, 32'h11, 6'd5, 4'h2));
    @(negedge i_clk);
    idle_inputs();
    checks++; if (o_iss_vld !== 1'b0) begin errors++; $display("FAIL wake_wait1 got %b exp 0", o_iss_vld); end
    @(negedge i_clk);
    checks++; if (o_iss_vld !== 1'b0) begin errors++; $display("FAIL wake_wait2 got %b exp 0", o_iss_vld); end
    drive_wb1(6'd9, 32'hDEAD);
    // No combinational path from writeback to issue
    #1;
    checks++; if (o_iss_vld !== 1'b0) begin errors++; $display("FAIL wake_same_cycle got %b exp 0", o_iss_vld); end
    @(negedge i_clk);
    idle_inputs();
    checks++; if (o_iss_vld !== 1'b1) begin errors++; $display("FAIL wake_iss_vld got %b exp 1", o_iss_vld); end
    got_pkt = {o_iss_srcopr1, o_iss_srcopr2, o_iss_rrftag, o_iss_alu_op};
    exp_pkt = pop_exp();
    checks++; if (got_pkt !== exp_pkt) begin errors++; $display("FAIL wake_pkt got %h exp %h", got_pkt, exp_pkt); end
    i_iss_rdy = 1'b1;
    @(negedge i_clk);
    i_iss_rdy = 1'b0;
    checks++; if (o_ent_cnt !== 3'd0) begin errors++; $display("FAIL wake_cnt got %0d exp 0", o_ent_cnt); end
  endtask

  task automatic test_bypass();
    @(negedge i_clk);
    drive_dp(1'b1, 32'h77, 1'b0, 32'd12, 6'd7, 4'h3);
    drive_wb0(6'd12, 32'h42);
    exp_q.push_back(pack(32'h77, 32'h42, 6'd7, 4'h3));
    @(negedge i_clk);
    idle_inputs();
    checks++; if (o_iss_vld !== 1'b1) begin errors++; $display("FAIL bypass_iss_vld got %b exp 1", o_iss_vld); end
    got_pkt = {o_iss_srcopr1, o_iss_srcopr2, o_iss_rrftag, o_iss_alu_op};
    exp_pkt = pop_exp();
    checks++; if (got_pkt !== exp_pkt) begin errors++; $display("FAIL bypass_pkt got %h exp %h", got_pkt, exp_pkt); end
    i_iss_rdy = 1'b1;
    @(negedge i_clk);
    i_iss_rdy = 1'b0;
    checks++; if (o_ent_cnt !== 3'd0) begin errors++; $display("FAIL bypass_cnt got %0d exp 0", o_ent_cnt); end
  endtask

  task automatic test_full();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      checks++; if (o_dp_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_%0d got %b exp 1", k, o_dp_rdy); end
      checks++; if (o_ent_cnt !== 3'(k)) begin errors++; $display("FAIL full_cnt_%0d got %0d exp %0d", k, o_ent_cnt, k); end
      a = $urandom;
      b = $urandom_range(0, 1000);
      drive_dp(1'b1, a, 1'b1, b, 6'(20 + k), 4'(k));
      exp_q.push_back(pack(a, b, 6'(20 + k), 4'(k)));
    end
    @(negedge i_clk);
    checks++; if (o_dp_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_low got %b exp 0", o_dp_rdy); end
    checks++; if (o_ent_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt4 got %0d exp 4", o_ent_cnt); end
    drive_dp(1'b1, 32'hBAD, 1'b1, 32'hBAD, 6'd63, 4'hF);
    @(negedge i_clk);
    idle_inputs();
    checks++; if (o_ent_cnt !== 3'd4) begin errors++; $display("FAIL full_drop_cnt got %0d exp 4", o_ent_cnt); end
    got_pkt = {o_iss_srcopr1, o_iss_srcopr2, o_iss_rrftag, o_iss_alu_op};
    exp_pkt = pop_exp();
    checks++; if (got_pkt !== exp_pkt) begin errors++; $display("FAIL full_pkt0 got %h exp %h", got_pkt, exp_pkt); end
    i_iss_rdy = 1'b1;
    #1;
    // Same-cycle issue must not raise dispatch ready
    checks++; if (o_dp_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_same_cycle got %b exp 0", o_dp_rdy); end
    @(negedge i_clk);
    checks++; if (o_dp_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_after got %b exp 1", o_dp_rdy); end
    checks++; if (o_ent_cnt !== 3'd3) begin errors++; $display("FAIL full_cnt3 got %0d exp 3", o_ent_cnt); end
    for (int k = 1; k < 4; k++) begin
      checks++; if (o_iss_vld !== 1'b1) begin errors++; $display("FAIL full_drain_vld_%0d got %b exp 1", k, o_iss_vld); end
      got_pkt = {o_iss_srcopr1, o_iss_srcopr2, o_iss_rrftag, o_iss_alu_op};
      exp_pkt = pop_exp();
      checks++; if (got_pkt !== exp_pkt) begin errors++; $display("FAIL full_pkt%0d got %h exp %h", k, got_pkt, exp_pkt); end
      @(negedge i_clk);
    end
    i_iss_rdy = 1'b0;
    checks++; if (o_ent_cnt !== 3'd0) begin errors++; $display("FAIL full_drained_cnt got %0d exp 0", o_ent_cnt); end
    checks++; if (o_iss_vld !== 1'b0) begin errors++; $display("FAIL full_dropped_vld got %b exp 0", o_iss_vld); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a;
    a = $urandom;
    @(negedge i_clk);
    drive_dp(1'b1, a, 1'b1, ~a, 6'd40, 4'h5);
    exp_q.push_back(pack(a, ~a, 6'd40, 4'h5));
    @(negedge i_clk);
    idle_inputs();
    checks++; if (o_ent_cnt !== 3'd1) begin errors++; $display("FAIL b2b_cnt1 got %0d exp 1", o_ent_cnt); end
    got_pkt = {o_iss_srcopr1, o_iss_srcopr2, o_iss_rrftag, o_iss_alu_op};
    exp_pkt = pop_exp();
    checks++; if (got_pkt !== exp_pkt) begin errors++; $display("FAIL b2b_pkt0 got %h exp %h", got_pkt, exp_pkt); end
    i_iss_rdy = 1'b1;
    drive_dp(1'b1, a + 32'd1, 1'b1, a + 32'd2, 6'd41, 4'h6);
    exp_q.push_back(pack(a + 32'd1, a + 32'd2, 6'd41, 4'h6));
    @(negedge i_clk);
    idle_inputs();
    checks++; if (o_ent_cnt !== 3'd1) begin errors++; $display("FAIL b2b_cnt_same got %0d exp 1", o_ent_cnt); end
    got_pkt = {o_iss_srcopr1, o_iss_srcopr2, o_iss_rrftag, o_iss_alu_op};
    exp_pkt = pop_exp();
    checks++; if (got_pkt !== exp_pkt) begin errors++; $display("FAIL b2b_pkt1 got %h exp %h", got_pkt, exp_pkt); end
    @(negedge i_clk);
    i_iss_rdy = 1'b0;
    checks++; if (o_ent_cnt !== 3'd0) begin errors++; $display("FAIL b2b_cnt0 got %0d exp 0", o_ent_cnt); end
  endtask

  task automatic test_priority();
    // Issue order is e1, e0 (after wakeup on tag 2), e3, e2 (after tag 20)
    exp_q.push_back(pack(32'h21, 32'h22, 6'd51, 4'h2));
    exp_q.push_back(pack(32'hAAAA, 32'h10, 6'd50, 4'h1));
    exp_q.push_back(pack(32'h41, 32'h42, 6'd53, 4'h4));
    exp_q.push_back(pack(32'h30, 32'hBBBB, 6'd52, 4'h3));
    @(negedge i_clk); drive_dp(1'b0, 32'd2, 1'b1, 32'h10, 6'd50, 4'h1);
    @(negedge i_clk); drive_dp(1'b1, 32'h21, 1'b1, 32'h22, 6'd51, 4'h2);
    @(negedge i_clk); drive_dp(1'b1, 32'h30, 1'b0, 32'd20, 6'd52, 4'h3);
    @(negedge i_clk); drive_dp(1'b1, 32'h41, 1'b1, 32'h42, 6'd53, 4'h4);
    @(negedge i_clk);
    idle_inputs();
    checks++; if (o_ent_cnt !== 3'd4) begin errors++; $display("FAIL prio_cnt got %0d exp 4", o_ent_cnt); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_iss_vld !== 1'b1) begin errors++; $display("FAIL prio_vld_%0d got %b exp 1", k, o_iss_vld); end
      got_pkt = {o_iss_srcopr1, o_iss_srcopr2, o_iss_rrftag, o_iss_alu_op};
      exp_pkt = pop_exp();
      checks++; if (got_pkt !== exp_pkt) begin errors++; $display("FAIL prio_pkt%0d got %h exp %h", k, got_pkt, exp_pkt); end
      i_iss_rdy = 1'b1;
      if (k == 0) drive_wb0(6'd2, 32'hAAAA);
      @(negedge i_clk);
      idle_inputs();
    end
    i_iss_rdy = 1'b0;
    checks++; if (o_iss_vld !== 1'b0) begin errors++; $display("FAIL prio_wait_vld got %b exp 0", o_iss_vld); end
    drive_wb1(6'd20, 32'hBBBB);
    @(negedge i_clk);
    idle_inputs();
    checks++; if (o_iss_vld !== 1'b1) begin errors++; $display("FAIL prio_last_vld got %b exp 1", o_iss_vld); end
    got_pkt = {o_iss_srcopr1, o_iss_srcopr2, o_iss_rrftag, o_iss_alu_op};
    exp_pkt = pop_exp();
    checks++; if (got_pkt !== exp_pkt) begin errors++; $display("FAIL prio_pkt3 got %h exp %h", got_pkt, exp_pkt); end
    i_iss_rdy = 1'b1;
    @(negedge i_clk);
    i_iss_rdy = 1'b0;
    checks++; if (o_ent_cnt !== 3'd0) begin errors++; $display("FAIL prio_cnt0 got %0d exp 0", o_ent_cnt); end
  endtask

  task automatic test_flush();
    @(negedge i_clk); drive_dp(1'b0, 32'd30, 1'b1, 32'd1, 6'd60, 4'h1);
    @(negedge i_clk); drive_dp(1'b1, 32'd2, 1'b0, 32'd31, 6'd61, 4'h2);
    @(negedge i_clk); drive_dp(1'b1, 32'd3, 1'b1, 32'd4, 6'd62, 4'h3);
    @(negedge i_clk);
    idle_inputs();
    checks++; if (o_ent_cnt !== 3'd3) begin errors++; $display("FAIL flush_pre_cnt got %0d exp 3", o_ent_cnt); end
    checks++; if (o_iss_vld !== 1'b1) begin errors++; $display("FAIL flush_pre_vld got %b exp 1", o_iss_vld); end
    i_flush = 1'b1;
    drive_dp(1'b1, 32'd5, 1'b1, 32'd6, 6'd63, 4'h4);
    drive_wb0(6'd30, 32'h99);
    @(negedge i_clk);
    idle_inputs();
    checks++; if (o_ent_cnt !== 3'd0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", o_ent_cnt); end
    checks++; if (o_iss_vld !== 1'b0) begin errors++; $display("FAIL flush_vld got %b exp 0", o_iss_vld); end
    checks++; if (o_dp_rdy !== 1'b1) begin errors++; $display("FAIL flush_rdy got %b exp 1", o_dp_rdy); end
    @(negedge i_clk);
    checks++; if (o_iss_vld !== 1'b0) begin errors++; $display("FAIL flush_vld_later got %b exp 0", o_iss_vld); end
  endtask

  task automatic test_async_reset();
    @(negedge i_clk); drive_dp(1'b1, 32'd7, 1'b1, 32'd8, 6'd10, 4'h9);
    @(negedge i_clk); drive_dp(1'b0, 32'd33, 1'b1, 32'd9, 6'd11, 4'h2);
    @(negedge i_clk);
    idle_inputs();
    checks++; if (o_ent_cnt !== 3'd2) begin errors++; $display("FAIL arst_pre_cnt got %0d exp 2", o_ent_cnt); end
    checks++; if (o_iss_vld !== 1'b1) begin errors++; $display("FAIL arst_pre_vld got %b exp 1", o_iss_vld); end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_ent_cnt !== 3'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", o_ent_cnt); end
    checks++; if (o_iss_vld !== 1'b0) begin errors++; $display("FAIL arst_vld got %b exp 0", o_iss_vld); end
    checks++; if (o_dp_rdy !== 1'b1) begin errors++; $display("FAIL arst_rdy got %b exp 1", o_dp_rdy); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++; if (o_ent_cnt !== 3'd0) begin errors++; $display("FAIL arst_post_cnt got %0d exp 0", o_ent_cnt); end
    checks++; if (o_iss_vld !== 1'b0) begin errors++; $display("FAIL arst_post_vld got %b exp 0", o_iss_vld); end
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_iss_rdy = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full();
    test_back_to_back();
    test_priority();
    test_flush();
    test_async_reset();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
